// File: rtl/mem_sys_param.sv
// Multi-channel scratch memory. One x-buffer (ch 0) and several weight buffers share
// a single address/write-data bus. Each channel has its own request lines and its own
// registered read-data slice. Bad requests are rejected with an error code. A per-channel
// clear sequencer zeroes one whole channel, one word per cycle.
module mem_sys_param #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        rd_rq,
  input  logic [NUM_CH-1:0]        wr_rq,
  input  logic [NUM_CH-1:0]        clr_rq,
  input  logic [ADDR_W-1:0]        rw_address,
  input  logic [DATA_W-1:0]        write_data,
  output logic [NUM_CH*DATA_W-1:0] read_data,
  output logic [NUM_CH-1:0]        rd_valid,
  output logic                     busy,
  output logic [1:0]               err_code
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(3 * NUM_CH + 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_MULTI = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_BUSY  = 2'd3
  } err_t;

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [CH_W-1:0]           clrCh_q, clrCh_d;
  logic                      busy_q, busy_d;
  err_t                      err_q, err_d;
  logic [NUM_CH*DATA_W-1:0]  readData_q, readData_d;
  logic [NUM_CH-1:0]         rdValid_q, rdValid_d;

  logic [CNT_W-1:0]  reqCnt;
  logic [CH_W-1:0]   reqCh;
  logic              isClr;
  logic              isWr;
  logic              inRange;
  logic [PTR_W-1:0]  addrIdx;
  logic [DATA_W-1:0] rdWord;

  logic              memWe;
  logic [CH_W-1:0]   memWCh;
  logic [PTR_W-1:0]  memWAddr;
  logic [DATA_W-1:0] memWData;

  // Count every individual request bit (rd+wr on one channel counts as two) and find the requesting channel
  always_comb begin
    reqCnt = '0;
    reqCh  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      reqCnt = reqCnt + CNT_W'(rd_rq[i]) + CNT_W'(wr_rq[i]) + CNT_W'(clr_rq[i]);
      if (rd_rq[i] || wr_rq[i] || clr_rq[i]) begin
        reqCh = CH_W'(i);
      end
    end
  end

  assign isClr   = |clr_rq;
  assign isWr    = |wr_rq;
  assign inRange = {1'b0, rw_address} < (ADDR_W + 1)'(DEPTH);
  assign addrIdx = rw_address[PTR_W-1:0];
  assign rdWord  = mem[reqCh][addrIdx];

  // Next-state logic: request acceptance in IDLE, word-by-word zeroing in CLEAR
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clrCh_d    = clrCh_q;
    busy_d     = busy_q;
    err_d      = err_q;
    readData_d = readData_q;
    rdValid_d  = '0;
    memWe      = 1'b0;
    memWCh     = reqCh;
    memWAddr   = addrIdx;
    memWData   = write_data;
    case (state_q)
      IDLE: begin
        if (reqCnt == '0) begin
          err_d = err_q;
        end else if (reqCnt > CNT_W'(1)) begin
          err_d = ERR_MULTI;
        end else if (isClr) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          ptr_d   = '0;
          clrCh_d = reqCh;
          readData_d[reqCh*DATA_W +: DATA_W] = '0;
          err_d   = ERR_OK;
        end else if (!inRange) begin
          err_d = ERR_RANGE;
        end else if (isWr) begin
          memWe = 1'b1;
          err_d = ERR_OK;
        end else begin
          readData_d[reqCh*DATA_W +: DATA_W] = rdWord;
          rdValid_d[reqCh] = 1'b1;
          err_d = ERR_OK;
        end
      end
      CLEAR: begin
        memWe    = 1'b1;
        memWCh   = clrCh_q;
        memWAddr = ptr_q;
        memWData = '0;
        if (reqCnt != '0) begin
          err_d = ERR_BUSY;
        end
        if (ptr_q == PTR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset aborts any clear in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      clrCh_q    <= '0;
      busy_q     <= 1'b0;
      err_q      <= ERR_OK;
      readData_q <= '0;
      rdValid_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clrCh_q    <= clrCh_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      readData_q <= readData_d;
      rdValid_q  <= rdValid_d;
    end
  end

  // Storage array, deliberately not reset so a partial clear leaves untouched words intact
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWCh][memWAddr] <= memWData;
    end
  end

  assign read_data = readData_q;
  assign rd_valid  = rdValid_q;
  assign busy      = busy_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_mem_sys_param.sv
// Directed self-checking bench for mem_sys_param with a 16-word depth so the clear
// sequence stays short; the out-of-range cases use both addr 16 and wide addresses
// whose low bits alias a valid word.
module tb_mem_sys_param;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 17;
  localparam int DEPTH  = 16;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        rd_rq;
  logic [NUM_CH-1:0]        wr_rq;
  logic [NUM_CH-1:0]        clr_rq;
  logic [ADDR_W-1:0]        rw_address;
  logic [DATA_W-1:0]        write_data;
  logic [NUM_CH*DATA_W-1:0] read_data;
  logic [NUM_CH-1:0]        rd_valid;
  logic                     busy;
  logic [1:0]               err_code;

  int errors = 0;
  int checks = 0;
  logic [NUM_CH*DATA_W-1:0] expRd;

  mem_sys_param #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_rq     (rd_rq),
    .wr_rq     (wr_rq),
    .clr_rq    (clr_rq),
    .rw_address(rw_address),
    .write_data(write_data),
    .read_data (read_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .err_code  (err_code)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] rd, input logic [NUM_CH-1:0] wr,
                               input logic [NUM_CH-1:0] clr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data);
    rd_rq      = rd;
    wr_rq      = wr;
    clr_rq     = clr;
    rw_address = addr;
    write_data = data;
    @(posedge clk);
    #1;
    rd_rq  = '0;
    wr_rq  = '0;
    clr_rq = '0;
  endtask

  function automatic logic [NUM_CH-1:0] chMask(input int ch);
    logic [NUM_CH-1:0] m;
    m = '0;
    m[ch] = 1'b1;
    return m;
  endfunction

  task automatic writeWord(input int ch, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    applyStimulus('0, chMask(ch), '0, addr, data);
  endtask

  task automatic readCheck(input string tag, input int ch, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] expected);
    applyStimulus(chMask(ch), '0, '0, addr, '0);
    expRd[ch*DATA_W +: DATA_W] = expected;
    checkOutput({tag, "_data"}, read_data, expRd);
    checkOutput({tag, "_vld"}, rd_valid, chMask(ch));
    checkOutput({tag, "_err"}, err_code, 2'd0);
  endtask

  initial begin
    rst        = 1'b0;
    rd_rq      = '0;
    wr_rq      = '0;
    clr_rq     = '0;
    rw_address = '0;
    write_data = '0;
    expRd      = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data", read_data, '0);
    checkOutput("rst_vld", rd_valid, '0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_err", err_code, 2'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: ch2 addr 1..8 = 10..17, read addr 5
    for (int a = 1; a <= 8; a++) begin
      writeWord(2, ADDR_W'(a), DATA_W'(9 + a));
    end
    readCheck("t1_rd", 2, 17'd5, 8'd14);
    applyStimulus('0, '0, '0, '0, '0);
    checkOutput("t1_vld_drop", rd_valid, '0);
    checkOutput("t1_hold", read_data, expRd);

    // T2: independent slices
    writeWord(1, 17'd3, 8'h31);
    writeWord(3, 17'd3, 8'h33);
    readCheck("t2_ch1", 1, 17'd3, 8'h31);
    readCheck("t2_ch3", 3, 17'd3, 8'h33);

    // T3: multi-request, then range errors
    writeWord(0, 17'd0, 8'h44);
    writeWord(0, 17'd1, 8'h55);
    applyStimulus(5'b00011, '0, '0, 17'd3, '0);
    checkOutput("t3_multi_err", err_code, 2'd1);
    checkOutput("t3_multi_vld", rd_valid, '0);
    checkOutput("t3_multi_data", read_data, expRd);
    applyStimulus(5'b00100, 5'b00100, '0, 17'd5, 8'h99);
    checkOutput("t3_rdwr_err", err_code, 2'd1);
    checkOutput("t3_rdwr_vld", rd_valid, '0);
    checkOutput("t3_rdwr_data", read_data, expRd);
    applyStimulus('0, 5'b00001, '0, 17'd16, 8'h77);
    checkOutput("t3_range16", err_code, 2'd2);
    applyStimulus('0, '0, '0, '0, '0);
    checkOutput("t3_err_hold", err_code, 2'd2);
    applyStimulus('0, 5'b00001, '0, 17'd1024, 8'h77);
    checkOutput("t3_range1024", err_code, 2'd2);
    applyStimulus('0, 5'b00001, '0, 17'h10001, 8'h77);
    checkOutput("t3_range_wide", err_code, 2'd2);
    applyStimulus(5'b00001, '0, '0, 17'h10000, '0);
    checkOutput("t3_rd_range_err", err_code, 2'd2);
    checkOutput("t3_rd_range_vld", rd_valid, '0);
    readCheck("t3_back0", 0, 17'd0, 8'h44);
    readCheck("t3_back1", 0, 17'd1, 8'h55);
    readCheck("t3_back_ch2", 2, 17'd5, 8'd14);

    // T6 part 1: write then read the next cycle
    writeWord(0, 17'd7, 8'h5A);
    readCheck("t6_wr_rd", 0, 17'd7, 8'h5A);

    // T4: fill ch4, clear it, request mid-clear is dropped
    writeWord(0, 17'd9, 8'h09);
    for (int a = 0; a < DEPTH; a++) begin
      writeWord(4, ADDR_W'(a), 8'hFF);
    end
    readCheck("t4_full", 4, 17'd0, 8'hFF);
    applyStimulus('0, '0, 5'b10000, 17'h1FFFF, '0);
    expRd[4*DATA_W +: DATA_W] = '0;
    checkOutput("t4_busy_on", busy, 1'b1);
    checkOutput("t4_clr_data", read_data, expRd);
    checkOutput("t4_clr_err", err_code, 2'd0);
    for (int k = 1; k < DEPTH; k++) begin
      if (k == 5) begin
        applyStimulus('0, 5'b00001, '0, 17'd9, 8'hEE);
        checkOutput("t4_wr_busy_err", err_code, 2'd3);
      end else if (k == 8) begin
        applyStimulus(5'b00010, '0, '0, 17'd3, '0);
        checkOutput("t4_rd_busy_err", err_code, 2'd3);
        checkOutput("t4_rd_busy_vld", rd_valid, '0);
        checkOutput("t4_rd_busy_data", read_data, expRd);
      end else begin
        applyStimulus('0, '0, '0, '0, '0);
      end
      checkOutput($sformatf("t4_busy_%0d", k), busy, 1'b1);
    end
    applyStimulus('0, '0, '0, '0, '0);
    checkOutput("t4_busy_off", busy, 1'b0);
    for (int a = 0; a < DEPTH; a++) begin
      readCheck($sformatf("t4_zero_%0d", a), 4, ADDR_W'(a), 8'h00);
    end
    readCheck("t4_ch0_dropped", 0, 17'd9, 8'h09);
    readCheck("t4_ch0_a7", 0, 17'd7, 8'h5A);
    readCheck("t4_ch1", 1, 17'd3, 8'h31);
    readCheck("t4_ch2", 2, 17'd5, 8'd14);
    readCheck("t4_ch3", 3, 17'd3, 8'h33);

    // T5: clear ch1, reset after 5 busy cycles
    for (int a = 0; a < DEPTH; a++) begin
      writeWord(1, ADDR_W'(a), 8'hAA);
    end
    readCheck("t5_full", 1, 17'd15, 8'hAA);
    applyStimulus('0, '0, 5'b00010, '0, '0);
    checkOutput("t5_busy_on", busy, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus('0, '0, '0, '0, '0);
    end
    checkOutput("t5_busy_pre", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t5_busy_abort", busy, 1'b0);
    checkOutput("t6_rst_data", read_data, '0);
    checkOutput("t6_rst_vld", rd_valid, '0);
    checkOutput("t6_rst_err", err_code, 2'd0);
    expRd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_busy_after", busy, 1'b0);
    for (int a = 0; a < DEPTH; a++) begin
      readCheck($sformatf("t5_rd_%0d", a), 1, ADDR_W'(a), (a < 5) ? 8'h00 : 8'hAA);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
